// File: rtl/bus_memory_pkg.sv
// Shared widths and types for the MemoryBus slave endpoint and its read-response buffer.
package bus_memory_pkg;

  localparam int DATA_WIDTH         = 24;
  localparam int ADDRESS_WIDTH      = 32;
  localparam int MASTER_ID_WIDTH    = 8;
  localparam int MEMORY_DEPTH_WIDTH = 12;
  localparam int INDEX_WIDTH        = MEMORY_DEPTH_WIDTH;

  typedef struct packed {
    logic [MASTER_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]      data;
  } response_t;

  // Addresses outside the served window wrap onto the RAM instead of faulting.
  function automatic logic [INDEX_WIDTH-1:0] word_index(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [ADDRESS_WIDTH-1:0] base
  );
    return INDEX_WIDTH'(addr - base);
  endfunction

endpackage

// File: rtl/bus_memory_responder_if.sv
// MemoryBus request (ms) and response (sm) channels between one master and one slave.
interface bus_memory_responder_if;
  import bus_memory_pkg::*;

  logic [MASTER_ID_WIDTH-1:0] msID;
  logic [ADDRESS_WIDTH-1:0]   msAddress;
  logic [DATA_WIDTH-1:0]      msData;
  logic                       msWrite;
  logic                       msValid;
  logic                       msReady;
  logic [MASTER_ID_WIDTH-1:0] smID;
  logic [DATA_WIDTH-1:0]      smData;
  logic                       smValid;
  logic                       smReady;

  modport master (
    output msID, msAddress, msData, msWrite, msValid, smReady,
    input  msReady, smID, smData, smValid
  );

  modport slave (
    input  msID, msAddress, msData, msWrite, msValid, smReady,
    output msReady, smID, smData, smValid
  );

endinterface

// File: rtl/bus_memory_responder_response_fifo.sv
// Synchronous FIFO of tagged read responses; push and pop may coincide at any occupancy.
module response_fifo
  import bus_memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  response_t              push_data,
  input  logic                   pop,
  output response_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  response_t        slot_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      slot_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage is not reset, so the head is forced to zero whenever nothing is buffered.
  assign pop_data = empty ? '0 : slot_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/bus_memory_responder.sv
// MemoryBus slave: posted word writes and ID-tagged reads against an internal block RAM.
module bus_memory_responder
  import bus_memory_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                       RESPONSE_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_memory_responder_if.slave bus
);

  localparam int              CW      = $clog2(RESPONSE_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_L = (CW+1)'(RESPONSE_DEPTH);

  logic [DATA_WIDTH-1:0]      mem [0:(1<<INDEX_WIDTH)-1];
  logic [INDEX_WIDTH-1:0]     word_idx;
  logic                       accept;
  logic                       rd_accept;
  logic                       wr_accept;
  logic                       inflight_reg;
  logic [MASTER_ID_WIDTH-1:0] s1_id_reg;
  logic [DATA_WIDTH-1:0]      s1_data_reg;
  response_t                  s1_resp;
  response_t                  head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [CW:0]                committed;

  // Every accepted read owns a FIFO slot before it is issued, counting the one still in S1.
  assign committed   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
  assign bus.msReady = reset && !fifo_full && (committed < DEPTH_L);

  assign accept    = bus.msValid && bus.msReady;
  assign rd_accept = accept && !bus.msWrite;
  assign wr_accept = accept && bus.msWrite;
  assign word_idx  = word_index(bus.msAddress, BASE_ADDRESS);

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[word_idx] <= bus.msData;
    end
    if (rd_accept) begin
      s1_data_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_reg <= 1'b0;
      s1_id_reg    <= '0;
    end else begin
      inflight_reg <= rd_accept;
      if (rd_accept) begin
        s1_id_reg <= bus.msID;
      end
    end
  end

  assign s1_resp = {s1_id_reg, s1_data_reg};

  response_fifo #(
    .DEPTH (RESPONSE_DEPTH)
  ) u_response_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (s1_resp),
    .pop       (bus.smReady),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.smValid = !fifo_empty;
  assign bus.smID    = head.id;
  assign bus.smData  = head.data;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: latency, backpressure, streaming, aliasing, mid-run reset.
module tb_bus_memory_responder;
  import bus_memory_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bus_memory_responder_if u_if ();
  bus_memory_responder_if a_if ();

  bus_memory_responder u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  bus_memory_responder #(
    .BASE_ADDRESS (32'h0000_1000)
  ) a_dut (
    .clock (clock),
    .reset (reset),
    .bus   (a_if.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_mem [16];
  response_t   exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request from a negedge and return at the negedge after its accepting edge.
  task automatic issue(input logic [7:0] id, input logic [31:0] addr, input logic [23:0] data, input bit wr);
    int waitc = 0;
    u_if.msID      = id;
    u_if.msAddress = addr;
    u_if.msData    = data;
    u_if.msWrite   = wr;
    u_if.msValid   = 1'b1;
    while (!u_if.msReady && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    check("issue_ready", u_if.msReady, 1);
    if (wr) exp_mem[addr[3:0]] = data;
    $display("%s id=%0h addr=%0h data=%0h", wr ? "WR" : "RD", id, addr, data);
    @(negedge clock);
    u_if.msValid = 1'b0;
  endtask

  task automatic read_check(input logic [7:0] id, input int addr, input string tag);
    u_if.smReady = 1'b1;
    issue(id, 32'(addr), 24'h0, 1'b0);
    check({tag, "_n1_valid"}, u_if.smValid, 0);
    @(negedge clock);
    check({tag, "_valid"}, u_if.smValid, 1);
    check({tag, "_id"}, u_if.smID, id);
    check({tag, "_data"}, u_if.smData, exp_mem[addr]);
    $display("RSP id=%0h data=%0h", u_if.smID, u_if.smData);
    @(negedge clock);
  endtask

  task automatic stream(input int n, input int stall, input logic [7:0] id0, input bit alt,
                        input int budget, input string tag);
    int          issued = 0;
    int          got    = 0;
    int          cyc    = 0;
    logic [7:0]  id;
    response_t   r;
    while ((issued < n || got < n) && cyc < budget) begin
      u_if.smReady = (cyc >= stall);
      if (stall > 0 && cyc == stall) begin
        check({tag, "_accepted"}, issued, 4);
        check({tag, "_ready_low"}, u_if.msReady, 0);
        check({tag, "_held_id"}, u_if.smID, id0);
      end
      if (issued < n) begin
        id = alt ? ((issued % 2 == 0) ? 8'd1 : 8'd2) : id0 + 8'(issued);
        u_if.msID      = id;
        u_if.msAddress = 32'(issued);
        u_if.msData    = 24'h0;
        u_if.msWrite   = 1'b0;
        u_if.msValid   = 1'b1;
        if (stall == 0) check({tag, "_ready"}, u_if.msReady, 1);
        if (u_if.msReady) begin
          exp_q.push_back({id, exp_mem[issued]});
          issued++;
        end
      end else begin
        u_if.msValid = 1'b0;
      end
      if (u_if.smValid && u_if.smReady) begin
        if (exp_q.size() == 0) begin
          check({tag, "_spurious"}, u_if.smValid, 0);
        end else begin
          r = exp_q.pop_front();
          check({tag, "_id"}, u_if.smID, r.id);
          check({tag, "_data"}, u_if.smData, r.data);
          $display("RSP id=%0h data=%0h", u_if.smID, u_if.smData);
          got++;
        end
      end else if (stall == 0 && got > 0 && got < n) begin
        check({tag, "_bubble"}, u_if.smValid, 1);
      end
      @(negedge clock);
      cyc++;
    end
    u_if.msValid = 1'b0;
    check({tag, "_count"}, got, n);
  endtask

  task automatic alias_pair(input logic [31:0] waddr, input logic [23:0] data,
                            input logic [31:0] raddr, input logic [7:0] id, input string tag);
    a_if.smReady   = 1'b1;
    a_if.msID      = id;
    a_if.msAddress = waddr;
    a_if.msData    = data;
    a_if.msWrite   = 1'b1;
    a_if.msValid   = 1'b1;
    check({tag, "_wr_ready"}, a_if.msReady, 1);
    $display("WR alias addr=%0h data=%0h", waddr, data);
    @(negedge clock);
    a_if.msAddress = raddr;
    a_if.msWrite   = 1'b0;
    check({tag, "_rd_ready"}, a_if.msReady, 1);
    $display("RD alias id=%0h addr=%0h", id, raddr);
    @(negedge clock);
    a_if.msValid = 1'b0;
    @(negedge clock);
    check({tag, "_valid"}, a_if.smValid, 1);
    check({tag, "_id"}, a_if.smID, id);
    check({tag, "_data"}, a_if.smData, data);
    @(negedge clock);
  endtask

  initial begin
    u_if.msID = '0; u_if.msAddress = '0; u_if.msData = '0;
    u_if.msWrite = 1'b0; u_if.msValid = 1'b0; u_if.smReady = 1'b0;
    a_if.msID = '0; a_if.msAddress = '0; a_if.msData = '0;
    a_if.msWrite = 1'b0; a_if.msValid = 1'b0; a_if.smReady = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 24'h0;

    repeat (3) @(negedge clock);
    check("rst_msReady", u_if.msReady, 0);
    check("rst_smValid", u_if.smValid, 0);
    check("rst_smID", u_if.smID, 0);
    check("rst_smData", u_if.smData, 0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_msReady", u_if.msReady, 1);
    check("post_rst_smValid", u_if.smValid, 0);

    issue(8'd3, 32'd5, 24'h00ABCD, 1'b1);
    read_check(8'd3, 5, "raw5");

    for (int a = 0; a < 16; a++) issue(8'd0, 32'(a), 24'h5A0000 + 24'(a) * 24'h000101, 1'b1);

    stream(8, 10, 8'h20, 1'b0, 60, "bp");
    stream(16, 0, 8'h00, 1'b1, 60, "burst");

    alias_pair(32'h0000_1000, 24'h123456, 32'h0000_2000, 8'd7, "alias0");
    alias_pair(32'h0000_0FFF, 24'hBEEF01, 32'h0000_1FFF, 8'd9, "aliasTop");

    u_if.smReady = 1'b0;
    issue(8'h31, 32'd1, 24'h0, 1'b0);
    issue(8'h32, 32'd2, 24'h0, 1'b0);
    issue(8'h33, 32'd3, 24'h0, 1'b0);
    @(negedge clock);
    check("mid_buffered_valid", u_if.smValid, 1);
    check("mid_buffered_id", u_if.smID, 8'h31);
    check("mid_buffered_data", u_if.smData, exp_mem[1]);
    reset = 1'b0;
    #1;
    check("mid_rst_smValid", u_if.smValid, 0);
    check("mid_rst_msReady", u_if.msReady, 0);
    @(negedge clock);
    @(negedge clock);
    check("mid_rst_hold_smValid", u_if.smValid, 0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_release_smValid", u_if.smValid, 0);
    check("mid_release_msReady", u_if.msReady, 1);
    @(negedge clock);
    check("mid_release2_smValid", u_if.smValid, 0);
    read_check(8'h44, 2, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Slave-side endpoint of the MemoryBus protocol: accepts master requests on the ms channel, performs word writes and reads on an internal block RAM, and returns read data tagged with the requesting master's ID on the sm channel. It sits behind the bus interconnect as the backing store that RayMemory and the other masters target. Writes are posted and produce no response. Read responses are buffered so that sm-channel backpressure never loses data.

## Interface
- DATA_WIDTH, 24, word width on both channels and in the RAM
- ADDRESS_WIDTH, 32, msAddress width
- MASTER_ID_WIDTH, 8, msID/smID width
- MEMORY_DEPTH_WIDTH, 12, log2 of RAM words (4096)
- BASE_ADDRESS, 0, first word address served
- RESPONSE_DEPTH, 4, read-response FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all control state
- msID  in  MASTER_ID_WIDTH  requesting master
- msAddress  in  ADDRESS_WIDTH  word address
- msData  in  DATA_WIDTH  write data
- msWrite  in  1  1 = write, 0 = read
- msValid  in  1  request valid
- msReady  out  1  request can be accepted
- smID  out  MASTER_ID_WIDTH  ID of response at FIFO head
- smData  out  DATA_WIDTH  read data at FIFO head
- smValid  out  1  response valid
- smReady  in  1  master accepts response

## Operation
- Request accepted in the cycle where msValid && msReady; ms-side values are sampled only then.
- Word index = (msAddress − BASE_ADDRESS) truncated to MEMORY_DEPTH_WIDTH bits; out-of-window addresses alias, with no error.
- Write: RAM[index] ← msData at the accepting edge; no sm response.
- Read: RAM read at the accepting edge into a registered output (stage S1, holds {id, data}, inflight flag set). On the next edge, S1 is pushed into the response FIFO (sub-module).
- Credit rule: msReady = reset deasserted && (fifoCount + inflight) < RESPONSE_DEPTH. msReady is a function of registered state only. It never depends on msValid, msWrite or the same-cycle smReady pop, so the check is conservative. Writes are gated by the same credit.
- sm channel: smValid = FIFO non-empty; smID/smData = head entry. The head pops when smValid && smReady. Outputs hold stable while smValid && !smReady.
- Same-cycle FIFO push and pop is legal at any occupancy, including full.
- Ordering: responses return in request-accept order, regardless of master ID.
- RAW hazard: a read accepted after a write to the same index returns the new data. A read accepted in the same cycle as nothing else sees prior contents. Only one request per cycle exists.
- Reset (asserted at any time, including mid-burst): FIFO emptied, inflight cleared, and in-flight or buffered responses are dropped. RAM contents are not reset; simulation initial value is 0.

## Timing
- Reset values: msReady 0, smValid 0, smID 0, smData 0. msReady rises in the first cycle after reset is released.
- Read latency: accept in cycle N → smValid high in cycle N+2 (FIFO empty and not stalled).
- Throughput: one request per cycle sustained while smReady is held high.
- With smReady low, at most RESPONSE_DEPTH reads are accepted, then msReady falls. msReady recovers the cycle after a pop reduces the count.
- A write consumes one request slot and takes effect at its accept edge.

## Structure
- Package bus_memory_pkg: typedef response_t {id, data} parameterised via the package widths; localparam for index width.
- Sub-module response_fifo: synchronous FIFO of response_t with depth RESPONSE_DEPTH. It has push/pop/full/empty/count and asynchronous active-low reset, and is usable elsewhere on the bus.
- Top level holds the RAM array, S1 register, inflight flag and credit logic.

## Test plan
- Reset release: all outputs are 0 during reset; msReady = 1 one cycle after release, smValid = 0.
- Write 0x00ABCD to address 5 (ID 3), then read address 5 (ID 3) with smReady = 1: smValid in the read's N+2 cycle, with smID = 3 and smData = 0x00ABCD.
- Backpressure: smReady = 0 while issuing reads of addresses 0..7. Exactly 4 are accepted and msReady drops. Then raise smReady: 4 responses arrive in order with correct IDs, and the remaining reads complete.
- Back-to-back streaming of reads to addresses 0..15 with IDs alternating 1/2 and smReady = 1: msReady stays 1 throughout, 16 in-order responses arrive with matching IDs, and no bubbles occur after the first response.
- Aliasing with BASE_ADDRESS = 0x1000: write 0x123456 to 0x1000, read 0x2000 → 0x123456.
- Reset mid-operation: with 3 responses buffered, assert reset for 2 cycles. smValid drops immediately and stays 0 after release. A subsequent read of previously written data returns the pre-reset RAM value.
